// File: rtl/paint_scheduler_if.sv
// Request/engine bundle between three paint requesters, the scheduler and the fill engine.
// The scheduler side uses the slave modport.
interface paint_scheduler_if #(
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 7,
    parameter int COLOR_BITS = 3
);
    logic [2:0]              req_valid;
    logic [2:0]              req_ready;
    logic [3*X_BITS-1:0]     req_x_start;
    logic [3*X_BITS-1:0]     req_x_end;
    logic [3*Y_BITS-1:0]     req_y_start;
    logic [3*Y_BITS-1:0]     req_y_end;
    logic [3*COLOR_BITS-1:0] req_color;
    logic [8:0]              req_config;

    logic [X_BITS-1:0]       eng_x_start;
    logic [X_BITS-1:0]       eng_x_end;
    logic [Y_BITS-1:0]       eng_y_start;
    logic [Y_BITS-1:0]       eng_y_end;
    logic [COLOR_BITS-1:0]   eng_color;
    logic [2:0]              eng_config;
    logic                    eng_start;
    logic                    eng_done;

    logic [1:0]              grant_id;
    logic                    sched_busy;
    logic                    timeout_err;
    logic [15:0]             job_count;
    logic [7:0]              reject_count;

    modport master (
        output req_valid, req_x_start, req_x_end, req_y_start, req_y_end,
        output req_color, req_config, eng_done,
        input  req_ready, eng_x_start, eng_x_end, eng_y_start, eng_y_end,
        input  eng_color, eng_config, eng_start, grant_id, sched_busy,
        input  timeout_err, job_count, reject_count
    );

    modport slave (
        input  req_valid, req_x_start, req_x_end, req_y_start, req_y_end,
        input  req_color, req_config, eng_done,
        output req_ready, eng_x_start, eng_x_end, eng_y_start, eng_y_end,
        output eng_color, eng_config, eng_start, grant_id, sched_busy,
        output timeout_err, job_count, reject_count
    );
endinterface

// File: rtl/paint_scheduler.sv
// Round-robin arbiter feeding one fill engine from three paint requesters.
// Rejects empty rectangles and aborts engine jobs that overrun the timeout.
module paint_scheduler #(
    parameter int X_BITS         = 8,
    parameter int Y_BITS         = 7,
    parameter int COLOR_BITS     = 3,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input logic               Clck,
    input logic               Reset,
    paint_scheduler_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [1:0]            r_last_grant;
    logic [1:0]            r_grant;
    logic [2:0]            r_req_ready;
    logic                  r_eng_start;
    logic [X_BITS-1:0]     r_xs, r_xe;
    logic [Y_BITS-1:0]     r_ys, r_ye;
    logic [COLOR_BITS-1:0] r_color;
    logic [2:0]            r_config;
    logic                  r_busy;
    logic                  r_timeout;
    logic [15:0]           r_jobs;
    logic [7:0]            r_rejects;
    logic [CW-1:0]         r_wait_cnt;

    logic [1:0]            w_c0, w_c1, w_c2;
    logic                  w_found;
    logic [1:0]            w_grant;
    logic [X_BITS-1:0]     w_xs, w_xe;
    logic [Y_BITS-1:0]     w_ys, w_ye;
    logic [COLOR_BITS-1:0] w_color;
    logic [2:0]            w_config;
    logic                  w_ok;
    logic                  w_issue_ok;

    function automatic logic [1:0] nxt(input logic [1:0] g);
        return (g == 2'd2) ? 2'd0 : g + 2'd1;
    endfunction

    // Search order starts one past the last served requester.
    always_comb begin
        w_c0    = nxt(r_last_grant);
        w_c1    = nxt(w_c0);
        w_c2    = nxt(w_c1);
        w_found = 1'b1;
        w_grant = w_c0;
        if (bus.req_valid[w_c0])      w_grant = w_c0;
        else if (bus.req_valid[w_c1]) w_grant = w_c1;
        else if (bus.req_valid[w_c2]) w_grant = w_c2;
        else                          w_found = 1'b0;
    end

    always_comb begin
        w_xs     = bus.req_x_start[int'(w_grant)*X_BITS +: X_BITS];
        w_xe     = bus.req_x_end[int'(w_grant)*X_BITS +: X_BITS];
        w_ys     = bus.req_y_start[int'(w_grant)*Y_BITS +: Y_BITS];
        w_ye     = bus.req_y_end[int'(w_grant)*Y_BITS +: Y_BITS];
        w_color  = bus.req_color[int'(w_grant)*COLOR_BITS +: COLOR_BITS];
        w_config = bus.req_config[int'(w_grant)*3 +: 3];
        w_ok     = (w_xe > w_xs) && (w_ye > w_ys);
    end

    assign w_issue_ok = (r_xe > r_xs) && (r_ye > r_ys);

    always_ff @(posedge Clck) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 2'd2;
            r_grant      <= 2'd0;
            r_req_ready  <= 3'b000;
            r_eng_start  <= 1'b0;
            r_xs         <= '0;
            r_xe         <= '0;
            r_ys         <= '0;
            r_ye         <= '0;
            r_color      <= '0;
            r_config     <= '0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
            r_jobs       <= '0;
            r_rejects    <= '0;
            r_wait_cnt   <= '0;
        end else begin
            r_req_ready <= 3'b000;
            r_eng_start <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        // Pulses are pre-registered so they appear during ISSUE.
                        r_state     <= S_ISSUE;
                        r_busy      <= 1'b1;
                        r_grant     <= w_grant;
                        r_xs        <= w_xs;
                        r_xe        <= w_xe;
                        r_ys        <= w_ys;
                        r_ye        <= w_ye;
                        r_color     <= w_color;
                        r_config    <= w_config;
                        r_req_ready <= 3'b001 << w_grant;
                        r_eng_start <= w_ok;
                    end
                end
                S_ISSUE: begin
                    r_last_grant <= r_grant;
                    if (w_issue_ok) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= '0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (r_rejects != 8'hFF) r_rejects <= r_rejects + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (bus.eng_done) begin
                        r_state <= S_DONE;
                    end else if (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_jobs     <= r_jobs + 16'd1;
                    r_wait_cnt <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.eng_start    = r_eng_start;
    assign bus.eng_x_start  = r_xs;
    assign bus.eng_x_end    = r_xe;
    assign bus.eng_y_start  = r_ys;
    assign bus.eng_y_end    = r_ye;
    assign bus.eng_color    = r_color;
    assign bus.eng_config   = r_config;
    assign bus.grant_id     = r_grant;
    assign bus.sched_busy   = r_busy;
    assign bus.timeout_err  = r_timeout;
    assign bus.job_count    = r_jobs;
    assign bus.reject_count = r_rejects;
endmodule
